// File: rtl/jtag_scan_controller.sv
// jtag_scan_controller
//   JTAG master scan engine. Takes one transaction at a time (instruction plus
//   an optional test vector of 8/16/24/32 bits), walks the TAP through the IR
//   and DR scans, and returns the TDO bits captured during both shifts.
//   BYPASS scans are lengthened by one bit; that leading bit is the target's
//   bypass capture and is reported through rspBypassErr.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   reqValid/Ready  request handshake; reqReady only while idle
//   reqInstruction  instruction, shifted LSB first
//   reqIrOnly       skip the DR scan
//   reqWidthSel     vector length 8*(sel+1), clamped to DR_WIDTH
//   reqVector       TDI data, shifted LSB first
//   tck, tms, tdi   JTAG pins driven to the target
//   tdo             JTAG data from the target, synchronous to clk
//   rspValid        one-clk response strobe
//   rspIrCapture    TDO bits captured during Shift-IR
//   rspData         TDO bits captured during Shift-DR, zero-extended
//   rspBypassErr    BYPASS scan whose captured bypass bit was 1
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_INIT  | 5 TCKs tms=1 (Test-Logic-Reset), 1 TCK tms=0 (Run-Test/Idle)
// S_IDLE  | TAP parked in Run-Test/Idle, waiting for a request
// S_IR    | 1,1,0,0 into Shift-IR, shift instruction, Update-IR (+Idle if IR-only)
// S_DR    | 1,0,0 into Shift-DR, shift vector, Update-DR, back to Idle
// S_DONE  | one clk with rspValid high

module jtag_scan_controller #(
    parameter int IR_WIDTH      = 5,
    parameter int DR_WIDTH      = 32,
    parameter int TCK_DIV       = 2,
    parameter int BYPASS_OPCODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reqValid,
    output logic                reqReady,
    input  logic [IR_WIDTH-1:0] reqInstruction,
    input  logic                reqIrOnly,
    input  logic [1:0]          reqWidthSel,
    input  logic [DR_WIDTH-1:0] reqVector,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo,
    output logic                rspValid,
    output logic [IR_WIDTH-1:0] rspIrCapture,
    output logic [DR_WIDTH-1:0] rspData,
    output logic                rspBypassErr
);

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_IR   = 3'd2;
    localparam logic [2:0] S_DR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int PH_W  = $clog2(2 * TCK_DIV);
    localparam int IX_W  = 6;
    localparam int IRI_W = $clog2(IR_WIDTH);
    localparam int DRI_W = $clog2(DR_WIDTH);

    localparam logic [PH_W-1:0]     PH_RISE   = PH_W'(TCK_DIV - 1);
    localparam logic [PH_W-1:0]     PH_HIGH   = PH_W'(TCK_DIV);
    localparam logic [PH_W-1:0]     PH_LAST   = PH_W'(2 * TCK_DIV - 1);
    localparam logic [IX_W-1:0]     IRW       = IX_W'(IR_WIDTH);
    localparam logic [IX_W-1:0]     DRW       = IX_W'(DR_WIDTH);
    localparam logic [IR_WIDTH-1:0] BYPASS_IR = IR_WIDTH'(BYPASS_OPCODE);

    logic [2:0]          state;
    logic [PH_W-1:0]     phase;
    logic [IX_W-1:0]     idx;
    logic [IR_WIDTH-1:0] req_instr;
    logic                req_ir_only;
    logic                req_bypass;
    logic [DR_WIDTH-1:0] req_vector;
    logic [IX_W-1:0]     dr_bits;

    logic                scanning;
    logic                end_tck;
    logic                accept;
    logic [IX_W-1:0]     tck_total;
    logic [2:0]          nxt_state;
    logic [IX_W-1:0]     nxt_idx;
    logic [PH_W-1:0]     phase_nxt;
    logic                tms_nxt;
    logic                tdi_nxt;
    logic [2:0]          len_sel;
    logic [IX_W-1:0]     len_raw;
    logic [IX_W-1:0]     len_eff;
    logic                bypass_req;

    always_comb begin
        scanning = (state == S_INIT) || (state == S_IR) || (state == S_DR);
        end_tck  = (phase == PH_LAST);
        accept   = (state == S_IDLE) && reqValid && reqReady;

        len_sel    = {1'b0, reqWidthSel} + 3'd1;
        len_raw    = {len_sel, 3'b000};
        len_eff    = (len_raw > DRW) ? DRW : len_raw;
        bypass_req = (reqInstruction == BYPASS_IR) && !reqIrOnly;

        case (state)
            S_INIT:  tck_total = 6'd6;
            S_IR:    tck_total = req_ir_only ? IRW + 6'd6 : IRW + 6'd5;
            S_DR:    tck_total = dr_bits + 6'd5;
            default: tck_total = 6'd1;
        endcase

        nxt_state = state;
        nxt_idx   = idx;
        if (accept) begin
            nxt_state = S_IR;
            nxt_idx   = '0;
        end else if (state == S_DONE) begin
            nxt_state = S_IDLE;
        end else if (scanning && end_tck) begin
            if (idx == tck_total - 6'd1) begin
                nxt_idx = '0;
                if (state == S_INIT)
                    nxt_state = S_IDLE;
                else if (state == S_IR && !req_ir_only)
                    nxt_state = S_DR;
                else
                    nxt_state = S_DONE;
            end else begin
                nxt_idx = idx + 6'd1;
            end
        end

        phase_nxt = (scanning && !end_tck) ? phase + PH_W'(1) : '0;

        // Pin values for the TCK that starts when phase wraps to 0.
        tms_nxt = 1'b0;
        tdi_nxt = 1'b0;
        case (nxt_state)
            S_INIT: tms_nxt = (nxt_idx < 6'd5);
            S_IR: begin
                if (nxt_idx < 6'd2) begin
                    tms_nxt = 1'b1;
                end else if (nxt_idx < 6'd4) begin
                    tms_nxt = 1'b0;
                end else if (nxt_idx < IRW + 6'd4) begin
                    tms_nxt = (nxt_idx == IRW + 6'd3);
                    tdi_nxt = req_instr[IRI_W'(nxt_idx - 6'd4)];
                end else begin
                    tms_nxt = (nxt_idx == IRW + 6'd4);
                end
            end
            S_DR: begin
                if (nxt_idx == 6'd0) begin
                    tms_nxt = 1'b1;
                end else if (nxt_idx < 6'd3) begin
                    tms_nxt = 1'b0;
                end else if (nxt_idx < dr_bits + 6'd3) begin
                    tms_nxt = (nxt_idx == dr_bits + 6'd2);
                    // A BYPASS scan spends its first shift bit on the bypass
                    // capture, so the vector starts one bit later.
                    if (!req_bypass)
                        tdi_nxt = req_vector[DRI_W'(nxt_idx - 6'd3)];
                    else if (nxt_idx != 6'd3)
                        tdi_nxt = req_vector[DRI_W'(nxt_idx - 6'd4)];
                end else begin
                    tms_nxt = (nxt_idx == dr_bits + 6'd3);
                end
            end
            default: begin
                tms_nxt = 1'b0;
                tdi_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_INIT;
            phase        <= '0;
            idx          <= '0;
            tck          <= 1'b0;
            tms          <= 1'b1;
            tdi          <= 1'b0;
            reqReady     <= 1'b0;
            rspValid     <= 1'b0;
            rspIrCapture <= '0;
            rspData      <= '0;
            rspBypassErr <= 1'b0;
            req_instr    <= '0;
            req_ir_only  <= 1'b0;
            req_bypass   <= 1'b0;
            req_vector   <= '0;
            dr_bits      <= '0;
        end else begin
            state    <= nxt_state;
            idx      <= nxt_idx;
            phase    <= phase_nxt;
            tck      <= (phase_nxt >= PH_HIGH);
            rspValid <= (nxt_state == S_DONE);

            if (phase_nxt == '0) begin
                tms <= tms_nxt;
                tdi <= tdi_nxt;
            end

            if (state == S_IDLE)
                reqReady <= !accept;
            else if (state == S_DONE)
                reqReady <= 1'b1;

            if (accept) begin
                req_instr    <= reqInstruction;
                req_ir_only  <= reqIrOnly;
                req_bypass   <= bypass_req;
                req_vector   <= reqVector;
                dr_bits      <= len_eff + {5'd0, bypass_req};
                rspIrCapture <= '0;
                rspData      <= '0;
                rspBypassErr <= 1'b0;
            end

            // Capture on the last low clk, i.e. the rising TCK edge.
            if (phase == PH_RISE) begin
                if (state == S_IR && idx >= 6'd4 && idx < IRW + 6'd4)
                    rspIrCapture[IRI_W'(idx - 6'd4)] <= tdo;
                if (state == S_DR && idx >= 6'd3 && idx < dr_bits + 6'd3) begin
                    if (!req_bypass)
                        rspData[DRI_W'(idx - 6'd3)] <= tdo;
                    else if (idx == 6'd3)
                        rspBypassErr <= tdo;
                    else
                        rspData[DRI_W'(idx - 6'd4)] <= tdo;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_scan_controller.sv
// Bench for jtag_scan_controller. A behavioural IEEE 1149.1 TAP follows the
// DUT's tck/tms, serves TDO from per-transaction patterns and records TDI
// during the shift states; expectations come from the transaction fields.

module tb_jtag_scan_controller;

    localparam int IRW     = 5;
    localparam int DRW     = 32;
    localparam int DIV     = 2;
    localparam int BYPASS  = 0;

    localparam int TAP_TLR = 0,  TAP_RTI = 1,  TAP_SELDR = 2,  TAP_CAPDR = 3;
    localparam int TAP_SHDR = 4, TAP_EX1DR = 5, TAP_PAUDR = 6, TAP_EX2DR = 7;
    localparam int TAP_UPDR = 8, TAP_SELIR = 9, TAP_CAPIR = 10, TAP_SHIR = 11;
    localparam int TAP_EX1IR = 12, TAP_PAUIR = 13, TAP_EX2IR = 14, TAP_UPIR = 15;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            reqValid = 1'b0;
    logic            reqReady;
    logic [IRW-1:0]  reqInstruction = '0;
    logic            reqIrOnly = 1'b0;
    logic [1:0]      reqWidthSel = '0;
    logic [DRW-1:0]  reqVector = '0;
    logic            tck, tms, tdi, tdo;
    logic            rspValid;
    logic [IRW-1:0]  rspIrCapture;
    logic [DRW-1:0]  rspData;
    logic            rspBypassErr;

    int tests_run = 0;
    int tests_failed = 0;

    int          tap = TAP_RTI;
    int          ir_cnt = 0;
    int          dr_cnt = 0;
    int          tck_count = 0;
    int          stray_tdi = 0;
    int          pulse_count = 0;
    logic        ir_tdi [0:63];
    logic        dr_tdi [0:63];
    logic [63:0] ir_pat = '0;
    logic [63:0] dr_pat = '0;

    jtag_scan_controller #(
        .IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_DIV(DIV), .BYPASS_OPCODE(BYPASS)
    ) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady),
        .reqInstruction(reqInstruction), .reqIrOnly(reqIrOnly),
        .reqWidthSel(reqWidthSel), .reqVector(reqVector),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
        .rspValid(rspValid), .rspIrCapture(rspIrCapture),
        .rspData(rspData), .rspBypassErr(rspBypassErr)
    );

    always #5 clk = ~clk;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            TAP_TLR:   return m ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   return m ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: return m ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: return m ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  return m ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: return m ? TAP_UPDR  : TAP_PAUDR;
            TAP_PAUDR: return m ? TAP_EX2DR : TAP_PAUDR;
            TAP_EX2DR: return m ? TAP_UPDR  : TAP_SHDR;
            TAP_UPDR:  return m ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: return m ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: return m ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  return m ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: return m ? TAP_UPIR  : TAP_PAUIR;
            TAP_PAUIR: return m ? TAP_EX2IR : TAP_PAUIR;
            TAP_EX2IR: return m ? TAP_UPIR  : TAP_SHIR;
            default:   return m ? TAP_SELDR : TAP_RTI;
        endcase
    endfunction

    // Target TDO: pattern bit indexed by the number of shifts so far.
    assign tdo = (tap == TAP_SHIR && ir_cnt < 64) ? ir_pat[ir_cnt] :
                 (tap == TAP_SHDR && dr_cnt < 64) ? dr_pat[dr_cnt] : 1'b0;

    always @(posedge tck) begin
        tck_count <= tck_count + 1;
        if (tap == TAP_SHIR) begin
            if (ir_cnt < 64) ir_tdi[ir_cnt] <= tdi;
            ir_cnt <= ir_cnt + 1;
        end else if (tap == TAP_SHDR) begin
            if (dr_cnt < 64) dr_tdi[dr_cnt] <= tdi;
            dr_cnt <= dr_cnt + 1;
        end else if (tdi !== 1'b0) begin
            stray_tdi <= stray_tdi + 1;
        end
        if (tap == TAP_CAPIR) ir_cnt <= 0;
        if (tap == TAP_CAPDR) dr_cnt <= 0;
        tap <= tap_next(tap, tms);
    end

    always @(posedge clk) begin
        if (rspValid === 1'b1) pulse_count <= pulse_count + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        int n;
        int p0;
        p0 = pulse_count;
        @(negedge clk);
        reset = 1'b1;
        reqValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_tck", 64'(tck), 64'd0);
        check_eq("rst_tms", 64'(tms), 64'd1);
        check_eq("rst_tdi", 64'(tdi), 64'd0);
        check_eq("rst_ready", 64'(reqReady), 64'd0);
        check_eq("rst_rspvalid", 64'(rspValid), 64'd0);
        check_eq("rst_ircap", 64'(rspIrCapture), 64'd0);
        check_eq("rst_data", 64'(rspData), 64'd0);
        check_eq("rst_byperr", 64'(rspBypassErr), 64'd0);
        reset = 1'b0;
        n = 0;
        while (reqReady !== 1'b1 && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check_eq("init_clks", 64'(n), 64'd25);
        check_eq("init_tap_idle", 64'(tap), 64'(TAP_RTI));
        check_eq("init_no_pulse", 64'(pulse_count - p0), 64'd0);
    endtask

    task automatic run_txn(input logic [IRW-1:0] instr, input logic ir_only,
                           input logic [1:0] sel, input logic [DRW-1:0] vec,
                           input logic [IRW-1:0] irp, input logic [63:0] drp);
        int          len, nbits, exp_tcks, n, t0, p0, s0;
        logic        byp, got;
        logic [63:0] exp_data, exp_vec, obs;
        len = 8 * (int'(sel) + 1);
        if (len > DRW) len = DRW;
        byp = (int'(instr) == BYPASS) && !ir_only;
        nbits = ir_only ? 0 : len + int'(byp);
        exp_tcks = ir_only ? IRW + 6 : IRW + len + 10 + int'(byp);
        exp_data = '0;
        exp_vec = '0;
        if (!ir_only) begin
            for (int i = 0; i < len; i++) begin
                exp_data[i] = drp[i + int'(byp)];
                exp_vec[i] = vec[i];
            end
        end
        ir_pat = 64'(irp);
        dr_pat = drp;

        n = 0;
        while (reqReady !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        reqInstruction = instr;
        reqIrOnly = ir_only;
        reqWidthSel = sel;
        reqVector = vec;
        reqValid = 1'b1;
        t0 = tck_count;
        p0 = pulse_count;
        s0 = stray_tdi;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        check_eq("ready_drop", 64'(reqReady), 64'd0);

        // Busy period: inputs wiggle and must be ignored.
        n = 0;
        got = 1'b0;
        while (!got && n < 1000) begin
            reqValid = 1'($urandom);
            reqInstruction = IRW'($urandom);
            reqIrOnly = 1'($urandom);
            reqWidthSel = 2'($urandom);
            reqVector = $urandom;
            @(posedge clk);
            n++;
            @(negedge clk);
            if (rspValid === 1'b1) got = 1'b1;
        end
        reqValid = 1'b0;
        check_eq("rsp_latency", 64'(n), 64'(4 * exp_tcks));
        check_eq("tck_total", 64'(tck_count - t0), 64'(exp_tcks));
        check_eq("ir_capture", 64'(rspIrCapture), 64'(irp));
        check_eq("rsp_data", 64'(rspData), exp_data);
        check_eq("bypass_err", 64'(rspBypassErr), byp ? 64'(drp[0]) : 64'd0);
        check_eq("ready_in_done", 64'(reqReady), 64'd0);
        obs = '0;
        for (int i = 0; i < IRW; i++) obs[i] = ir_tdi[i];
        check_eq("ir_tdi", obs, 64'(instr));
        if (!ir_only) begin
            obs = '0;
            for (int i = 0; i < len; i++) obs[i] = dr_tdi[i + int'(byp)];
            check_eq("dr_tdi", obs, exp_vec);
            check_eq("dr_shift_cnt", 64'(dr_cnt), 64'(nbits));
        end
        check_eq("stray_tdi", 64'(stray_tdi - s0), 64'd0);
        check_eq("tap_idle", 64'(tap), 64'(TAP_RTI));
        @(posedge clk);
        @(negedge clk);
        check_eq("pulse_width", 64'(rspValid), 64'd0);
        check_eq("ready_after", 64'(reqReady), 64'd1);
        check_eq("data_hold", 64'(rspData), exp_data);
        @(posedge clk);
        @(negedge clk);
        check_eq("pulse_count", 64'(pulse_count - p0), 64'd1);
    endtask

    initial begin
        int n;
        int p0;
        logic [IRW-1:0] ins;
        logic [31:0] a;
        logic [31:0] b;

        do_reset();

        run_txn(5'h1A, 1'b1, 2'd0, 32'h0, 5'b00001, 64'h0);
        run_txn(5'h02, 1'b0, 2'd3, 32'hDEADBEEF, 5'h0C, {32'h0, 32'hDEADBEEF});
        run_txn(5'h00, 1'b0, 2'd0, 32'h000000A5, 5'h11, {55'h0, 8'hA5, 1'b0});
        run_txn(5'h00, 1'b0, 2'd0, 32'h000000A5, 5'h11, {55'h0, 8'hA5, 1'b1});

        // Reset in the middle of Shift-DR.
        n = 0;
        while (reqReady !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        dr_pat = {$urandom, $urandom};
        reqInstruction = 5'h02;
        reqIrOnly = 1'b0;
        reqWidthSel = 2'd3;
        reqVector = $urandom;
        reqValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        n = 0;
        while (!(tap == TAP_SHDR && dr_cnt >= 4) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_shift_dr", 64'(tap), 64'(TAP_SHDR));
        p0 = pulse_count;
        do_reset();
        check_eq("abort_no_pulse", 64'(pulse_count - p0), 64'd0);
        run_txn(5'h02, 1'b0, 2'd1, 32'h00003C5A, 5'h15, {32'h0, 32'hF0F0_9669});

        for (int k = 0; k < 24; k++) begin
            ins = ($urandom_range(0, 3) == 0) ? IRW'(BYPASS) : IRW'($urandom);
            a = $urandom;
            b = $urandom;
            run_txn(ins, ($urandom_range(0, 2) == 0), 2'($urandom), $urandom,
                    IRW'($urandom), {a, b});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/jtag_scan_controller.md
Name: jtag_scan_controller

Overview:
- Parametrised JTAG master scan engine, successor to the fixed-enum JTAG width/opcode definitions.
- Accepts one transaction at a time: an instruction plus an optional test vector of runtime-selectable width. Drives TCK/TMS/TDI through the full IEEE 1149.1 TAP sequence and returns the captured TDO data.
- Handles the BYPASS opcode natively (one-bit delay compensation and check).
- Sits between the AVIP sequencer/driver and the JTAG pin interface.

Parameters:
- IR_WIDTH, 5, instruction register width; legal 3..5.
- DR_WIDTH, 32, maximum test-vector width; legal 8..32, multiple of 8.
- TCK_DIV, 2, clk cycles per TCK half-period; legal >=1.
- BYPASS_OPCODE, 0, instruction value treated as BYPASS.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- reqValid  in  1  transaction request valid.
- reqReady  out  1  engine idle and able to accept a request.
- reqInstruction  in  IR_WIDTH  instruction to load, shifted LSB first.
- reqIrOnly  in  1  1 = instruction phase only, no DR scan.
- reqWidthSel  in  2  vector length: 0=8, 1=16, 2=24, 3=32 bits.
- reqVector  in  DR_WIDTH  TDI data, shifted LSB first.
- tck  out  1  JTAG test clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data in.
- tdo  in  1  JTAG data out from target; already synchronous to clk.
- rspValid  out  1  one-cycle pulse, response valid.
- rspIrCapture  out  IR_WIDTH  TDO bits captured during Shift-IR.
- rspData  out  DR_WIDTH  TDO bits captured during Shift-DR, zero-extended.
- rspBypassErr  out  1  BYPASS scan: captured bypass bit was not 0.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, reqReady=0, rspValid=0, rspIrCapture=0, rspData=0, rspBypassErr=0.
- TCK generation:
  - Each TCK period is TCK_DIV clks low followed by TCK_DIV clks high.
  - tms/tdi update on the first clk of the low phase.
  - tdo is sampled on the last clk of the low phase (the rising TCK edge).
- Top-level FSM: INIT -> IDLE -> IR_SCAN -> DR_SCAN -> DONE -> IDLE.
- INIT: 5 TCKs with tms=1 (Test-Logic-Reset), then 1 TCK with tms=0 (Run-Test/Idle). reqReady rises the clk after INIT completes.
- IDLE:
  - reqReady=1, tck held 0, tms=0.
  - Request accepted when reqValid && reqReady; all req* fields are registered in that cycle.
  - reqReady drops the next clk.
- Effective DR length: L = min(8*(reqWidthSel+1), DR_WIDTH).
- BYPASS handling: when reqInstruction==BYPASS_OPCODE and reqIrOnly=0, the DR scan is L+1 bits.
- IR_SCAN TMS sequence:
  - 1,1,0,0 to reach Shift-IR.
  - IR_WIDTH shift TCKs; tms=1 on the last shift.
  - 1 TCK tms=1 to reach Update-IR.
  - If reqIrOnly: 1 TCK tms=0 to Idle, then go to DONE.
- DR_SCAN TMS sequence:
  - 1,0,0 to reach Shift-DR.
  - N shift TCKs; tms=1 on the last shift.
  - 1 TCK tms=1 to Update-DR.
  - 1 TCK tms=0 to Idle.
- TCK totals: full scan = IR_WIDTH+L+10; IR-only = IR_WIDTH+6; BYPASS adds 1.
- TDI/TDO bit mapping:
  - Shift bit i drives tdi=reqVector[i] and captures tdo into rspData[i].
  - BYPASS: shift bit 0 captures into rspBypassErr; bit k>=1 drives reqVector[k-1] and captures rspData[k-1].
  - tdi=0 whenever not in a shift state.
- DONE:
  - rspValid=1 for exactly one clk, on the clk after the last TCK high phase ends.
  - Response outputs hold until the next accept.
  - reqReady=1 on the following clk.
- Response output rules:
  - rspData bits >=L are 0.
  - rspData=0 for IR-only requests.
  - rspBypassErr=0 for non-BYPASS requests.
- reqValid with reqReady=0 is ignored; no queueing.
- Reset mid-operation: transaction abandoned, no rspValid, outputs return to reset values, INIT re-runs.

Test Plan:
- Reset, TCK_DIV=2 -> tms=1 for 5 TCKs, then tms=0 for 1 TCK; reqReady=1 after exactly 6*4+1 clks.
- IR_WIDTH=5, instr=5'h1A, irOnly=1, target TDO pattern 5'b00001 -> 11 TCKs; tdi during shift = 0,1,0,1,1; rspIrCapture=5'h01; rspData=0.
- Instr=5'h02, widthSel=3, vector 32'hDEADBEEF, target loopback tdo=tdi -> 47 TCKs; rspData=32'hDEADBEEF; single rspValid pulse.
- BYPASS: instr=0, widthSel=0, vector 8'hA5, target bypass register (1-bit delay, capture 0) -> 24 TCKs; rspData=8'hA5; rspBypassErr=0. Forced capture bit 1 -> rspBypassErr=1.
- DR_WIDTH=16, widthSel=3 -> L clamps to 16; 31 TCKs; rspData[15:0] correct.
- Assert reset mid-Shift-DR -> no rspValid; tms=1, tck=0 next clk; INIT repeats; a new request then completes correctly.
